// File: rtl/soc_simple_de1_key_pio.sv
// Avalon-MM input PIO for the DE1 keys/switches: synchronizes and debounces the pins,
// latches selected edges into a sticky register and raises a maskable level interrupt.
module soc_simple_de1_key_pio #(
   parameter int               WIDTH           = 4,
   parameter int               DEBOUNCE_CYCLES = 50000,
   parameter int               EDGE_TYPE       = 1,
   parameter logic [WIDTH-1:0] RESET_LEVEL     = '1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   // 0 and 1 both collapse to a single-cycle filter, so the terminal count is 0 there.
   localparam int               CNT_W    = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = (DEBOUNCE_CYCLES < 2) ? '0 : CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync1_q, sync2_q;
   logic [WIDTH-1:0] db_q, db_d;
   logic [WIDTH-1:0] db_prev_q;
   logic [CNT_W-1:0] cnt_q [WIDTH];
   logic [CNT_W-1:0] cnt_d [WIDTH];
   logic [WIDTH-1:0] irqmask_q, irqmask_d;
   logic [WIDTH-1:0] edgecap_q, edgecap_d;
   logic [WIDTH-1:0] edge_sel;
   logic [WIDTH-1:0] clr;
   logic             wr_en;

   assign wr_en = chipselect && !write_n;

   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         db_d[i]  = db_q[i];
         cnt_d[i] = '0;
         if (sync2_q[i] != db_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               db_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   always_comb begin
      case (EDGE_TYPE)
         0:       edge_sel = db_q & ~db_prev_q;
         1:       edge_sel = ~db_q & db_prev_q;
         default: edge_sel = db_q ^ db_prev_q;
      endcase
   end

   // Set has priority over the write-1-to-clear so a coincident edge is never lost.
   always_comb begin
      clr       = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
      edgecap_d = (edgecap_q & ~clr) | edge_sel;
      irqmask_d = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : irqmask_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q   <= RESET_LEVEL;
         sync2_q   <= RESET_LEVEL;
         db_q      <= RESET_LEVEL;
         db_prev_q <= RESET_LEVEL;
         cnt_q     <= '{default: '0};
         irqmask_q <= '0;
         edgecap_q <= '0;
      end else begin
         sync1_q   <= in_port;
         sync2_q   <= sync1_q;
         db_q      <= db_d;
         db_prev_q <= db_q;
         cnt_q     <= cnt_d;
         irqmask_q <= irqmask_d;
         edgecap_q <= edgecap_d;
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         2'd0:    readdata[WIDTH-1:0] = db_q;
         2'd2:    readdata[WIDTH-1:0] = irqmask_q;
         2'd3:    readdata[WIDTH-1:0] = edgecap_q;
         default: readdata = '0;
      endcase
   end

   assign irq = |(edgecap_q & irqmask_q);

   // Upper write-data bits have no storage behind them.
   generate
      if (WIDTH < 32) begin : g_wdata_hi
         logic unused_wdata_hi;
         assign unused_wdata_hi = ^writedata[31:WIDTH];
      end
   endgenerate

endmodule

// File: tb/tb_soc_simple_de1_key_pio.sv
// Scoreboard bench for soc_simple_de1_key_pio: reads push expected readdata/irq,
// a negedge monitor pops and compares whenever a read is presented on the bus.
module tb_soc_simple_de1_key_pio;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [3:0]  in_port;
   logic [31:0] readdata;
   logic        irq;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] data;
      logic        irq;
      string       name;
   } exp_t;

   exp_t sb_q[$];

   soc_simple_de1_key_pio #(
      .WIDTH(4),
      .DEBOUNCE_CYCLES(4),
      .EDGE_TYPE(1),
      .RESET_LEVEL(4'hF)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .address(address),
      .chipselect(chipselect),
      .write_n(write_n),
      .writedata(writedata),
      .in_port(in_port),
      .readdata(readdata),
      .irq(irq)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One bus cycle: reads queue their expectation, writes only drive the bus.
   task automatic applyStimulus(input logic [1:0] addr, input logic wr, input logic [31:0] wdata,
                                input logic [31:0] exp_data, input logic exp_irq, input string name);
      address    = addr;
      chipselect = 1'b1;
      write_n    = !wr;
      writedata  = wdata;
      if (!wr) sb_q.push_back('{exp_data, exp_irq, name});
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic rd(input logic [1:0] addr, input logic [31:0] exp_data, input logic exp_irq, input string name);
      applyStimulus(addr, 1'b0, 32'h0, exp_data, exp_irq, name);
   endtask

   task automatic wr(input logic [1:0] addr, input logic [31:0] wdata);
      applyStimulus(addr, 1'b1, wdata, 32'h0, 1'b0, "write");
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (chipselect && write_n) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_read: got read with empty scoreboard, expected none");
         end else begin
            e = sb_q.pop_front();
            checkOutput({e.name, "_data"}, readdata, e.data);
            checkOutput({e.name, "_irq"}, {31'h0, irq}, {31'h0, e.irq});
         end
      end
   end

   initial begin
      reset_n    = 1'b0;
      in_port    = 4'hF;
      chipselect = 1'b0;
      write_n    = 1'b1;
      address    = 2'd0;
      writedata  = 32'h0;
      tick(3);
      reset_n = 1'b1;

      rd(2'd0, 32'h0000000F, 1'b0, "rst_data");
      rd(2'd1, 32'h0, 1'b0, "rst_resv");
      rd(2'd2, 32'h0, 1'b0, "rst_mask");
      rd(2'd3, 32'h0, 1'b0, "rst_cap");

      // Key 0 pressed: data changes 5 edges after the sampling edge, capture one edge later.
      in_port = 4'hE;
      for (int j = 0; j < 6; j++) rd(2'd0, 32'hF, 1'b0, "press_wait");
      rd(2'd0, 32'hE, 1'b0, "press_data");
      rd(2'd3, 32'h1, 1'b0, "press_cap");

      wr(2'd2, 32'h1);
      rd(2'd2, 32'h1, 1'b1, "mask_irq");
      wr(2'd3, 32'h1);
      rd(2'd3, 32'h0, 1'b0, "clr_cap");
      wr(2'd0, 32'h0);
      rd(2'd0, 32'hE, 1'b0, "ro_data");
      wr(2'd1, 32'hFFFF_FFFF);
      rd(2'd1, 32'h0, 1'b0, "resv");

      // Three-cycle glitch on key 1 must be filtered out.
      in_port = 4'hC;
      tick(3);
      in_port = 4'hE;
      for (int j = 0; j < 8; j++) rd(2'd0, 32'hE, 1'b0, "glitch_data");
      rd(2'd3, 32'h0, 1'b0, "glitch_cap");

      // Clear of bit 2 lands on the same edge that captures its falling edge.
      in_port = 4'hA;
      tick(6);
      wr(2'd3, 32'h4);
      rd(2'd3, 32'h4, 1'b0, "collide_cap");
      rd(2'd0, 32'hA, 1'b0, "collide_data");
      wr(2'd2, 32'h4);
      rd(2'd2, 32'h4, 1'b1, "mask4_irq");
      wr(2'd3, 32'h4);
      rd(2'd3, 32'h0, 1'b0, "clr2_cap");

      // Reset in the middle of a count, then a full count after release.
      in_port = 4'h0;
      tick(4);
      reset_n = 1'b0;
      rd(2'd0, 32'hF, 1'b0, "rstmid_data");
      rd(2'd2, 32'h0, 1'b0, "rstmid_mask");
      rd(2'd3, 32'h0, 1'b0, "rstmid_cap");
      reset_n = 1'b1;
      for (int j = 0; j < 6; j++) rd(2'd0, 32'hF, 1'b0, "rel_wait");
      rd(2'd0, 32'h0, 1'b0, "rel_data");
      rd(2'd3, 32'hF, 1'b0, "rel_cap");

      for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
      if (sb_q.size() != 0) begin
         total++;
         bad++;
         $display("[TB] FAIL drain: got %0d pending, expected 0", sb_q.size());
      end
      tick(1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
